mem_wb_multi: RTL and testbench
===============================

Name: mem_wb_multi

Overview:
- Parametrised MEM/WB pipeline register for the multi-issue core; carries LANES parallel instruction slots from the MEM stage to write-back and difftest commit.
- Adds per-lane valid gating, stall/bubble/flush control, a merged LLbit update and a retired-instruction counter. Single-issue operation is LANES=1.
- Outputs feed the regfile write ports, the LLbit register and the debug commit interface.

Parameters:
- LANES, 2, number of issue slots (1..4); lane 0 is oldest
- DATA_W, 32, register data width
- PC_W, 32, PC and instruction width
- REG_AW, 5, architectural register address width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- mem_stall  in  1  MEM stage stalled (from ctrl)
- wb_stall  in  1  WB stage stalled (from ctrl)
- flush  in  1  exception/ertn flush, kills all MEM-stage lanes
- mem_valid  in  LANES  per-lane instruction valid, active-high
- mem_wd  in  LANES*REG_AW  per-lane destination register
- mem_wreg  in  LANES  per-lane register write enable
- mem_wdata  in  LANES*DATA_W  per-lane write data
- mem_inst_pc  in  LANES*PC_W  per-lane PC
- mem_instr  in  LANES*PC_W  per-lane instruction word
- mem_LLbit_we  in  LANES  per-lane LLbit write enable
- mem_LLbit_value  in  LANES  per-lane LLbit value
- wb_wd  out  LANES*REG_AW  registered destination
- wb_wreg  out  LANES  registered write enable, valid-gated
- wb_wdata  out  LANES*DATA_W  registered write data
- wb_LLbit_we  out  1  merged LLbit write enable
- wb_LLbit_value  out  1  merged LLbit value
- debug_commit_valid  out  LANES  active-high commit strobe per lane
- debug_commit_pc  out  LANES*PC_W  committed PC
- debug_commit_instr  out  LANES*PC_W  committed instruction
- retired_cnt  out  CNT_W  total committed instructions

Behaviour:
- Lane k occupies bits [k*W +: W] of every packed bus.
- Reset (rst=0, asynchronous): all outputs 0, retired_cnt=0. Reset deassertion has no effect until the next rising edge.
- Per-edge priority, highest first:
  1. flush=1: every lane is loaded as a bubble (valid, wreg, commit_valid, LLbit_we all 0; data, wd, pc and instr 0). flush wins over both stalls.
  2. wb_stall=1: all outputs hold their values; retired_cnt holds.
  3. mem_stall=1 with wb_stall=0: bubble is inserted (same as flush); the held MEM contents are not consumed.
  4. Otherwise: load a new group.
- Load rules:
  - wb_wreg[k] = mem_wreg[k] & mem_valid[k]
  - debug_commit_valid[k] = mem_valid[k] (active-high; no inversion)
  - wd, wdata, pc and instr are copied unconditionally.
- LLbit merge: the youngest (highest-index) lane with mem_valid & mem_LLbit_we wins. wb_LLbit_we = OR of those qualified enables; wb_LLbit_value = the winning lane's value, or 0 if none.
- retired_cnt increments by popcount(debug_commit_valid) every edge where wb_stall=0. This popcount uses the currently registered outputs, i.e. commits are counted one cycle after they appear. The counter wraps modulo 2^CNT_W without saturation.
- Latency: exactly 1 cycle MEM→WB when unstalled. There is no combinational path from inputs to outputs.
- Same-destination writes from two lanes are both presented; regfile priority (higher lane wins) is not this block's concern.
- Invalid lanes never assert wreg, commit_valid or LLbit, regardless of other inputs.

Test Plan:
- Reset then release: before the first edge, all outputs 0. Send lane0 {valid=1, wd=5, wreg=1, wdata=0xDEADBEEF, pc=0x1C000000} and lane1 valid=0. Next cycle: wb_wreg=2'b01, wb_wdata[31:0]=0xDEADBEEF, debug_commit_valid=2'b01; retired_cnt=1 one cycle later.
- Invalid gating: lane1 {valid=0, wreg=1, LLbit_we=1} → wb_wreg[1]=0, commit_valid[1]=0, wb_LLbit_we=0.
- LLbit merge: lane0 {LLbit_we=1, value=1} and lane1 {LLbit_we=1, value=0}, both valid → wb_LLbit_we=1, value=0. With lane1 invalid → value=1.
- Stalls:
  - wb_stall=1 for 3 cycles with changing inputs → outputs frozen, retired_cnt frozen.
  - mem_stall=1, wb_stall=0 → all-zero bubble next cycle.
- Flush priority: flush=1 together with wb_stall=1 and both lanes valid → bubble next cycle.
- Async reset mid-stream: drop rst between edges while both lanes committing → outputs and retired_cnt go to 0 immediately. Counter wrap with CNT_W=4: 8 two-lane commits from 0 → retired_cnt=0.

Source files
------------

// File: rtl/mem_wb_multi_if.sv
// mem_wb_multi_if: MEM->WB pipeline bundle for the multi-issue core.
//   master : MEM-stage side (drives lane payloads and stall/flush, sees WB/commit)
//   slave  : the MEM/WB register itself
// Lane k occupies bits [k*W +: W] of every packed bus; lane 0 is oldest.
interface mem_wb_multi_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic                     mem_stall;
  logic                     wb_stall;
  logic                     flush;
  logic [LANES-1:0]         mem_valid;
  logic [LANES*REG_AW-1:0]  mem_wd;
  logic [LANES-1:0]         mem_wreg;
  logic [LANES*DATA_W-1:0]  mem_wdata;
  logic [LANES*PC_W-1:0]    mem_inst_pc;
  logic [LANES*PC_W-1:0]    mem_instr;
  logic [LANES-1:0]         mem_LLbit_we;
  logic [LANES-1:0]         mem_LLbit_value;

  logic [LANES*REG_AW-1:0]  wb_wd;
  logic [LANES-1:0]         wb_wreg;
  logic [LANES*DATA_W-1:0]  wb_wdata;
  logic                     wb_LLbit_we;
  logic                     wb_LLbit_value;
  logic [LANES-1:0]         debug_commit_valid;
  logic [LANES*PC_W-1:0]    debug_commit_pc;
  logic [LANES*PC_W-1:0]    debug_commit_instr;
  logic [CNT_W-1:0]         retired_cnt;

  modport master (
    output mem_stall, wb_stall, flush, mem_valid, mem_wd, mem_wreg, mem_wdata,
           mem_inst_pc, mem_instr, mem_LLbit_we, mem_LLbit_value,
    input  wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value,
           debug_commit_valid, debug_commit_pc, debug_commit_instr, retired_cnt
  );

  modport slave (
    input  mem_stall, wb_stall, flush, mem_valid, mem_wd, mem_wreg, mem_wdata,
           mem_inst_pc, mem_instr, mem_LLbit_we, mem_LLbit_value,
    output wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value,
           debug_commit_valid, debug_commit_pc, debug_commit_instr, retired_cnt
  );
endinterface

// File: rtl/mem_wb_multi.sv
// mem_wb_multi: MEM/WB pipeline register carrying LANES issue slots to
// write-back and difftest commit, with valid gating, stall/bubble/flush,
// merged LLbit update and a retired-instruction counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_wb_multi_if.slave (MEM inputs, WB/commit outputs, stall/flush)
module mem_wb_multi #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_multi_if.slave  bus
);

  logic [LANES*REG_AW-1:0] wd_q,    wd_d;
  logic [LANES-1:0]        wreg_q,  wreg_d;
  logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
  logic                    llwe_q,  llwe_d;
  logic                    llval_q, llval_d;
  logic [LANES-1:0]        cv_q,    cv_d;
  logic [LANES*PC_W-1:0]   pc_q,    pc_d;
  logic [LANES*PC_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;

  logic                    ll_we_m;
  logic                    ll_val_m;
  logic [CNT_W-1:0]        pop;

  // LLbit merge: ascending scan so the youngest qualified lane wins.
  always_comb begin
    ll_we_m  = 1'b0;
    ll_val_m = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (bus.mem_valid[k] && bus.mem_LLbit_we[k]) begin
        ll_we_m  = 1'b1;
        ll_val_m = bus.mem_LLbit_value[k];
      end
    end
  end

  // Commits are counted from the registered strobes, one cycle after they appear.
  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pop = pop + CNT_W'(cv_q[k]);
    end
  end

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    llwe_d  = llwe_q;
    llval_d = llval_q;
    cv_d    = cv_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = bus.wb_stall ? cnt_q : cnt_q + pop;

    // flush beats wb_stall; mem_stall only bubbles when WB is free to advance.
    if (bus.flush || (!bus.wb_stall && bus.mem_stall)) begin
      wd_d    = '0;
      wreg_d  = '0;
      wdata_d = '0;
      llwe_d  = 1'b0;
      llval_d = 1'b0;
      cv_d    = '0;
      pc_d    = '0;
      instr_d = '0;
    end else if (!bus.wb_stall) begin
      wd_d    = bus.mem_wd;
      wreg_d  = bus.mem_wreg & bus.mem_valid;
      wdata_d = bus.mem_wdata;
      llwe_d  = ll_we_m;
      llval_d = ll_val_m;
      cv_d    = bus.mem_valid;
      pc_d    = bus.mem_inst_pc;
      instr_d = bus.mem_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      llwe_q  <= 1'b0;
      llval_q <= 1'b0;
      cv_q    <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      llwe_q  <= llwe_d;
      llval_q <= llval_d;
      cv_q    <= cv_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_wd              = wd_q;
  assign bus.wb_wreg            = wreg_q;
  assign bus.wb_wdata           = wdata_q;
  assign bus.wb_LLbit_we        = llwe_q;
  assign bus.wb_LLbit_value     = llval_q;
  assign bus.debug_commit_valid = cv_q;
  assign bus.debug_commit_pc    = pc_q;
  assign bus.debug_commit_instr = instr_q;
  assign bus.retired_cnt        = cnt_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
module tb_mem_wb_multi;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_wb_multi_if #(.LANES(2), .DATA_W(32), .PC_W(32), .REG_AW(5), .CNT_W(4)) bus ();

  mem_wb_multi #(.LANES(2), .DATA_W(32), .PC_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.mem_stall       = 1'b0;
    bus.wb_stall        = 1'b0;
    bus.flush           = 1'b0;
    bus.mem_valid       = '0;
    bus.mem_wd          = '0;
    bus.mem_wreg        = '0;
    bus.mem_wdata       = '0;
    bus.mem_inst_pc     = '0;
    bus.mem_instr       = '0;
    bus.mem_LLbit_we    = '0;
    bus.mem_LLbit_value = '0;
  endtask

  task automatic set_lane(input int k, input logic v, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          input logic llwe, input logic llval);
    bus.mem_valid[k]           = v;
    bus.mem_wd[k*5 +: 5]       = wd;
    bus.mem_wreg[k]            = wreg;
    bus.mem_wdata[k*32 +: 32]  = wdata;
    bus.mem_inst_pc[k*32 +: 32] = pc;
    bus.mem_instr[k*32 +: 32]  = pc ^ 32'h0280_0000;
    bus.mem_LLbit_we[k]        = llwe;
    bus.mem_LLbit_value[k]     = llval;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_inputs();
    #2;
    chk("rst_wreg",  64'(bus.wb_wreg), 64'h0);
    chk("rst_cv",    64'(bus.debug_commit_valid), 64'h0);
    chk("rst_wdata", 64'(bus.wb_wdata), 64'h0);
    chk("rst_cnt",   64'(bus.retired_cnt), 64'h0);
    rst = 1'b1;

    // first transaction: lane0 only
    set_lane(0, 1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1C00_0000, 1'b0, 1'b0);
    set_lane(1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("no_comb_path", 64'(bus.debug_commit_valid), 64'h0);
    step();
    chk("t1_wreg",  64'(bus.wb_wreg), 64'h1);
    chk("t1_wdata", 64'(bus.wb_wdata[31:0]), 64'hDEAD_BEEF);
    chk("t1_wd",    64'(bus.wb_wd), 64'h5);
    chk("t1_pc",    64'(bus.debug_commit_pc[31:0]), 64'h1C00_0000);
    chk("t1_instr", 64'(bus.debug_commit_instr[31:0]), 64'h1E80_0000);
    chk("t1_cv",    64'(bus.debug_commit_valid), 64'h1);
    chk("t1_cnt",   64'(bus.retired_cnt), 64'h0);
    clear_inputs();
    step();
    chk("t2_cnt", 64'(bus.retired_cnt), 64'h1);
    chk("t2_cv",  64'(bus.debug_commit_valid), 64'h0);

    // invalid lane gating
    set_lane(0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_lane(1, 1'b0, 5'd7, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b1);
    step();
    chk("inv_wreg",  64'(bus.wb_wreg), 64'h0);
    chk("inv_cv",    64'(bus.debug_commit_valid), 64'h1);
    chk("inv_llwe",  64'(bus.wb_LLbit_we), 64'h0);
    chk("inv_wd",    64'(bus.wb_wd), 64'hE0);
    chk("inv_wdata", 64'(bus.wb_wdata), 64'h0000_1234_0000_0000);
    chk("inv_cnt",   64'(bus.retired_cnt), 64'h1);

    // LLbit merge: youngest valid lane wins
    set_lane(0, 1'b1, 5'd1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
    set_lane(1, 1'b1, 5'd2, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("ll2_we",  64'(bus.wb_LLbit_we), 64'h1);
    chk("ll2_val", 64'(bus.wb_LLbit_value), 64'h0);
    chk("ll2_cv",  64'(bus.debug_commit_valid), 64'h3);
    chk("ll2_cnt", 64'(bus.retired_cnt), 64'h2);
    set_lane(0, 1'b1, 5'd1, 1'b1, 32'h1111_1111, 32'h0, 1'b1, 1'b1);
    set_lane(1, 1'b0, 5'd2, 1'b1, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
    step();
    chk("ll1_we",   64'(bus.wb_LLbit_we), 64'h1);
    chk("ll1_val",  64'(bus.wb_LLbit_value), 64'h1);
    chk("ll1_wreg", 64'(bus.wb_wreg), 64'h1);
    chk("ll1_cnt",  64'(bus.retired_cnt), 64'h4);

    // wb_stall freezes everything for 3 cycles while inputs change
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 1'b1, 5'(i + 10), 1'b1, 32'hAAAA_0000 + 32'(i), 32'h100, 1'b0, 1'b0);
      set_lane(1, 1'b1, 5'(i + 20), 1'b1, 32'hBBBB_0000 + 32'(i), 32'h104, 1'b1, 1'b0);
      step();
      chk("wbs_cv",    64'(bus.debug_commit_valid), 64'h1);
      chk("wbs_wdata", 64'(bus.wb_wdata), 64'h2222_2222_1111_1111);
      chk("wbs_llval", 64'(bus.wb_LLbit_value), 64'h1);
      chk("wbs_cnt",   64'(bus.retired_cnt), 64'h4);
    end
    bus.wb_stall = 1'b0;
    set_lane(0, 1'b1, 5'd3, 1'b1, 32'h3333_3333, 32'h200, 1'b0, 1'b0);
    set_lane(1, 1'b1, 5'd4, 1'b1, 32'h4444_4444, 32'h204, 1'b0, 1'b0);
    step();
    chk("rel_wdata", 64'(bus.wb_wdata), 64'h4444_4444_3333_3333);
    chk("rel_cv",    64'(bus.debug_commit_valid), 64'h3);
    chk("rel_llwe",  64'(bus.wb_LLbit_we), 64'h0);
    chk("rel_cnt",   64'(bus.retired_cnt), 64'h5);

    // mem_stall inserts a bubble
    bus.mem_stall = 1'b1;
    step();
    chk("ms_wreg",  64'(bus.wb_wreg), 64'h0);
    chk("ms_cv",    64'(bus.debug_commit_valid), 64'h0);
    chk("ms_wdata", 64'(bus.wb_wdata), 64'h0);
    chk("ms_pc",    64'(bus.debug_commit_pc), 64'h0);
    chk("ms_wd",    64'(bus.wb_wd), 64'h0);
    chk("ms_cnt",   64'(bus.retired_cnt), 64'h7);
    bus.mem_stall = 1'b0;
    step();
    chk("ms_rel_cv",  64'(bus.debug_commit_valid), 64'h3);
    chk("ms_rel_cnt", 64'(bus.retired_cnt), 64'h7);

    // flush beats wb_stall
    bus.flush    = 1'b1;
    bus.wb_stall = 1'b1;
    step();
    chk("fl_cv",    64'(bus.debug_commit_valid), 64'h0);
    chk("fl_wreg",  64'(bus.wb_wreg), 64'h0);
    chk("fl_wdata", 64'(bus.wb_wdata), 64'h0);
    chk("fl_cnt",   64'(bus.retired_cnt), 64'h7);
    bus.flush    = 1'b0;
    bus.wb_stall = 1'b0;
    step();
    chk("pf_cv",  64'(bus.debug_commit_valid), 64'h3);
    chk("pf_cnt", 64'(bus.retired_cnt), 64'h7);
    step();
    chk("pf2_cnt", 64'(bus.retired_cnt), 64'h9);

    // async reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("ar_cv",    64'(bus.debug_commit_valid), 64'h0);
    chk("ar_wdata", 64'(bus.wb_wdata), 64'h0);
    chk("ar_cnt",   64'(bus.retired_cnt), 64'h0);
    rst = 1'b1;

    // wrap: 8 two-lane commits from 0 in a 4-bit counter
    step();
    chk("wr_cnt0", 64'(bus.retired_cnt), 64'h0);
    for (int i = 0; i < 6; i++) step();
    step();
    chk("wr_cnt7", 64'(bus.retired_cnt), 64'hE);
    step();
    chk("wr_cnt8", 64'(bus.retired_cnt), 64'h0);
    step();
    chk("wr_cnt9", 64'(bus.retired_cnt), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
